// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake and serial-side signals of the piso_tx transmitter.
// The producer drives through the master modport; the transmitter uses slave.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output ser_out,
        output ser_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first, one bit per clock.
// A word is accepted from the valid/ready handshake in IDLE, shifted out over
// WIDTH cycles, then a one-cycle done pulse is shown back in IDLE.
// Build option: define PIPO_TX_PARITY_EN to append an even-parity bit as the
// last frame bit (adds the PARITY state and the parity accumulator).
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    piso_tx_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1
`ifdef PIPO_TX_PARITY_EN
        ,
        S_PARITY = 2'd2
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               w_accept;
    logic               w_last_bit;
    logic               w_frame_end;
    logic               w_ser_out;
    logic               w_ser_valid;
`ifdef PIPO_TX_PARITY_EN
    logic               r_par;
`endif

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and line outputs derived from state and flops only.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_frame_end = 1'b0;
        w_ser_out   = 1'b0;
        w_ser_valid = 1'b0;
        w_last_bit  = (r_cnt == CNT_W'(WIDTH - 1));
        case (r_state)
            S_IDLE: begin
                // load_ready is high exactly in IDLE, so valid alone accepts.
                if (bus.load_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_ser_out   = r_shift[0];
                w_ser_valid = 1'b1;
                if (w_last_bit) begin
`ifdef PIPO_TX_PARITY_EN
                    w_next      = S_PARITY;
`else
                    w_next      = S_IDLE;
                    w_frame_end = 1'b1;
`endif
                end
            end
`ifdef PIPO_TX_PARITY_EN
            S_PARITY: begin
                w_ser_out   = r_par;
                w_ser_valid = 1'b1;
                w_next      = S_IDLE;
                w_frame_end = 1'b1;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Shift register, bit counter and parity: load on accept, advance in SHIFT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
`ifdef PIPO_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift <= bus.data_in;
            r_cnt   <= '0;
`ifdef PIPO_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (r_state == S_SHIFT) begin
            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            r_cnt   <= r_cnt + CNT_W'(1);
`ifdef PIPO_TX_PARITY_EN
            r_par   <= r_par ^ r_shift[0];
`endif
        end
    end

    // Done pulse: registered on the edge that leaves the last frame bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_frame_end;
        end
    end

    assign bus.load_ready = (r_state == S_IDLE);
    assign bus.ser_out    = w_ser_out;
    assign bus.ser_valid  = w_ser_valid;
    assign bus.busy       = w_ser_valid;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx (WIDTH=8) with a frame-level model
// (queue of pending line bits) checked every cycle, plus literal frame checks.
module tb_piso_tx;

    localparam int WIDTH = 8;
`ifdef PIPO_TX_PARITY_EN
    localparam int F = WIDTH + 1;
`else
    localparam int F = WIDTH;
`endif

    logic clk;
    logic reset;
    logic chk_en;
    int   checks;
    int   failures;

    piso_tx_if #(.WIDTH(WIDTH)) bus ();

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queue of bits still to appear on the line, one per cycle.
    bit mq[$];
    bit m_done;
    bit m_idle;

    // History of DUT outputs, one entry per negedge, for literal frame checks.
    bit hv[$];
    bit ho[$];
    bit hd[$];

    task automatic check(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic checkv(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Model update: consume one pending bit per edge, queue a new frame when idle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_done = 1'b0;
        end else begin
            m_idle = (mq.size() == 0);
            m_done = 1'b0;
            if (!m_idle) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end else if (bus.load_valid) begin
                for (int i = 0; i < WIDTH; i++) mq.push_back(bus.data_in[i]);
`ifdef PIPO_TX_PARITY_EN
                mq.push_back(^bus.data_in);
`endif
            end
        end
    end

    // Per-cycle compare against the model, and output history capture.
    always @(negedge clk) begin
        hv.push_back(bus.ser_valid);
        ho.push_back(bus.ser_out);
        hd.push_back(bus.done);
        if (chk_en) begin
            check("ser_valid",  bus.ser_valid,  mq.size() != 0);
            check("busy",       bus.busy,       mq.size() != 0);
            check("ser_out",    bus.ser_out,    (mq.size() != 0) ? mq[0] : 1'b0);
            check("done",       bus.done,       m_done);
            check("load_ready", bus.load_ready, mq.size() == 0);
        end
    end

    task automatic hist_clear();
        hv.delete();
        ho.delete();
        hd.delete();
    endtask

    // Offer one word; it is accepted at the next edge, then data_in is scrambled.
    task automatic send(input logic [7:0] w);
        @(posedge clk); #2;
        hist_clear();
        bus.load_valid = 1'b1;
        bus.data_in    = w;
        @(posedge clk); #2;
        bus.load_valid = 1'b0;
        bus.data_in    = ~w;
    endtask

    // Frame bits start at history index b; done cycle is at b+F.
    task automatic check_frame(input string nm, input int b, input logic [7:0] w);
        logic [7:0] got;
        int nv;
        if (ho.size() < b + F + 1) begin
            checkv({nm, "_histlen"}, ho.size(), b + F + 1);
            return;
        end
        got = '0;
        nv  = 0;
        for (int i = 0; i < WIDTH; i++) got[i] = ho[b + i];
        for (int i = 0; i < F; i++) nv += int'(hv[b + i]);
        checkv({nm, "_data"},     int'(got), int'(w));
        checkv({nm, "_nvalid"},   nv, F);
        checkv({nm, "_predone"},  int'(hd[b + F - 1]), 0);
        checkv({nm, "_done"},     int'(hd[b + F]), 1);
        checkv({nm, "_gapvalid"}, int'(hv[b + F]), 0);
        checkv({nm, "_gapout"},   int'(ho[b + F]), 0);
    endtask

    task automatic check_par(input string nm, input int b, input logic p);
        checkv({nm, "_parity"}, int'(ho[b + WIDTH]), int'(p));
    endtask

    function automatic int done_count();
        int n;
        n = 0;
        foreach (hd[i]) n += int'(hd[i]);
        return n;
    endfunction

    initial begin
        checks         = 0;
        failures       = 0;
        chk_en         = 1'b0;
        reset          = 1'b0;
        bus.load_valid = 1'b0;
        bus.data_in    = '0;

        // Reset asserted between edges must act without a clock edge.
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_ser_valid",  bus.ser_valid,  1'b0);
        check("rst_busy",       bus.busy,       1'b0);
        check("rst_ser_out",    bus.ser_out,    1'b0);
        check("rst_done",       bus.done,       1'b0);
        check("rst_load_ready", bus.load_ready, 1'b1);
        chk_en = 1'b1;
        @(posedge clk); #2 reset = 1'b0;

        // Single frame 0xA5: 1,0,1,0,0,1,0,1 then done.
        send(8'hA5);
        repeat (F + 2) @(posedge clk);
        #2;
        check_frame("a5", 1, 8'hA5);
        checkv("a5_donecount", done_count(), 1);
`ifdef PIPO_TX_PARITY_EN
        check_par("a5", 1, 1'b0);
`endif

        // 0x07: parity bit 1.
        send(8'h07);
        repeat (F + 2) @(posedge clk);
        #2;
        check_frame("x07", 1, 8'h07);
`ifdef PIPO_TX_PARITY_EN
        check_par("x07", 1, 1'b1);
`endif

        // Back-to-back: valid held, 0x01 then 0x80, one done cycle between.
        @(posedge clk); #2;
        hist_clear();
        bus.load_valid = 1'b1;
        bus.data_in    = 8'h01;
        @(posedge clk); #2;
        bus.data_in    = 8'h80;
        repeat (F) @(posedge clk);
        @(posedge clk); #2;
        bus.load_valid = 1'b0;
        bus.data_in    = 8'h00;
        repeat (F + 2) @(posedge clk);
        #2;
        check_frame("b2b_first", 1, 8'h01);
        check_frame("b2b_second", F + 2, 8'h80);
        checkv("b2b_donecount", done_count(), 2);
`ifdef PIPO_TX_PARITY_EN
        check_par("b2b_first", 1, 1'b1);
        check_par("b2b_second", F + 2, 1'b1);
`endif

        // Input isolation: data_in goes to 0x00 right after 0xFF is accepted.
        send(8'hFF);
        repeat (F + 2) @(posedge clk);
        #2;
        check_frame("isol_ff", 1, 8'hFF);
`ifdef PIPO_TX_PARITY_EN
        check_par("isol_ff", 1, 1'b0);
`endif

        // Mid-frame reset during bit 3 of 0xFF.
        send(8'hFF);
        repeat (3) @(posedge clk);
        #2;
        check("mid_valid_before", bus.ser_valid, 1'b1);
        check("mid_out_before",   bus.ser_out,   1'b1);
        #1 reset = 1'b1;
        #1;
        check("mid_ser_valid",  bus.ser_valid,  1'b0);
        check("mid_busy",       bus.busy,       1'b0);
        check("mid_ser_out",    bus.ser_out,    1'b0);
        check("mid_done",       bus.done,       1'b0);
        check("mid_load_ready", bus.load_ready, 1'b1);
        @(posedge clk); #2;
        @(posedge clk); #2 reset = 1'b0;
        repeat (F + 2) @(posedge clk);
        #2;
        checkv("mid_no_done", done_count(), 0);

        // Recovery after reset: 0x3C.
        send(8'h3C);
        repeat (F + 2) @(posedge clk);
        #2;
        check_frame("x3c", 1, 8'h3C);
`ifdef PIPO_TX_PARITY_EN
        check_par("x3c", 1, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that serializes a WIDTH-bit word onto a single-bit line, LSB first, one bit per clock. It is the driving end of the single-bit sampled data path: the far side captures `ser_out` with plain D flip-flops on the same clock edge. It sits between a parallel producer using a valid/ready load handshake and the serial link. An optional even-parity bit is appended per frame.

## Interface
Parameters:
- `WIDTH`, default 8: data bits per frame. Legal range is WIDTH ≥ 2.

Ports:
- `clk`  input  1: clock. All state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `data_in`  input  WIDTH: parallel word. Sampled only on an accepted load.
- `load_valid`  input  1: producer offers `data_in`.
- `load_ready`  output  1: transmitter can accept a word. High only in IDLE.
- `ser_out`  output  1: serial data bit.
- `ser_valid`  output  1: `ser_out` carries a frame bit this cycle.
- `busy`  output  1: a frame is in progress.
- `done`  output  1: one-cycle pulse after the last bit of a frame.

## Operation
- Registers:
  - WIDTH-bit shift register.
  - Bit counter, width $clog2(WIDTH+1).
  - Parity accumulator.
  - FSM.
- FSM states and transitions:
  - IDLE: on `load_valid && load_ready`, go to SHIFT. Otherwise stay.
  - SHIFT: after the bit with index WIDTH-1, go to PARITY if PARITY_EN is defined, else go to IDLE.
  - PARITY: always go to IDLE after one cycle.
- Accept: when `load_valid && load_ready` is high at an edge:
  - Load `data_in` into the shift register.
  - Clear the counter and the parity accumulator.
- SHIFT:
  - `ser_out` = shift[0]. Shift right each cycle.
  - XOR the outgoing bit into parity.
  - Increment the counter.
- PARITY: `ser_out` = XOR of all WIDTH data bits (even parity).
- Outputs are registered. `ser_out`, `ser_valid` and `busy` are driven from state and flops, never combinationally from inputs.
- `load_valid` while not in IDLE: ignored, because `load_ready` is 0. The producer holds the word until accepted.
- Changes on `data_in` after acceptance have no effect on the frame in progress.
- Reset values, applied immediately on `reset` rising, independent of `clk`:
  - `ser_out`=0, `ser_valid`=0, `busy`=0, `done`=0, `load_ready`=1.
  - FSM=IDLE; counter and shift register cleared.
- Reset mid-frame: the frame is abandoned and `done` is not pulsed. The first edge after `reset` falls may accept a new load.

## Timing
- Let F = WIDTH, or WIDTH+1 with PARITY_EN.
- Load accepted at edge k:
  - Cycles k+1 … k+F: `ser_valid`=1, `busy`=1, `load_ready`=0.
  - `ser_out` = data bit i in cycle k+1+i; the parity bit is in cycle k+F.
- Cycle k+F+1: back in IDLE with `done`=1 (one cycle only), `ser_valid`=0, `ser_out`=0, `load_ready`=1.
  - A load presented in this cycle is accepted at its closing edge.
- Minimum frame period is F+1 cycles. Exactly one idle (`done`) cycle separates back-to-back frames.
- Latency from acceptance to the first bit on the line is 1 cycle.

## Configuration
- `PIPO_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in, F = WIDTH+1, and the last frame bit is even parity over the data bits.
  - Undefined: no PARITY state or parity logic, and F = WIDTH.
- The handshake and `done` rules are identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert `reset` between clock edges → all outputs take their reset values without waiting for a `clk` edge; `load_ready`=1.
- Single frame: load 0xA5 → `ser_out` 1,0,1,0,0,1,0,1 over 8 cycles with `ser_valid`=1; `done`=1 in the following cycle only.
- Parity build:
  - 0xA5 → parity bit 0 in the 9th cycle.
  - 0x07 → parity bit 1 in the 9th cycle.
  - `done` pulses in the 10th cycle.
- Back-to-back: hold `load_valid`=1 with 0x01 then 0x80 → frames 10000000 and 00000001, separated by exactly one cycle with `ser_valid`=0 and `done`=1.
- Mid-frame reset: assert `reset` during bit 3 of 0xFF → `ser_valid`, `busy` and `ser_out` drop to 0 immediately; no `done`. After release, load 0x3C → correct stream.
- Input isolation: change `data_in` to 0x00 one cycle after accepting 0xFF → eight 1s are transmitted.
